// File: rtl/invmat_loader.sv
// Element-stream to matrix loader for invmat: packs a row-major valid/ready stream
// into a flat N*N matrix, double-buffered (assembly + holding register).
module invmat_loader #(
  parameter int MAT_SIZE   = 5,
  parameter int MAT_DWIDTH = 46,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [MAT_DWIDTH-1:0]                 s_data,
  input  logic                                  s_valid,
  input  logic                                  s_last,
  output logic                                  s_ready,
  input  logic                                  ready,
  output logic                                  mat_vld,
  output logic [MAT_DWIDTH*MAT_SIZE*MAT_SIZE-1:0] mat_in,
  output logic                                  err,
  output logic [CNT_WIDTH-1:0]                  mat_count
);

  localparam int NUM_ELEM = MAT_SIZE * MAT_SIZE;
  localparam int FLAT_W   = MAT_DWIDTH * NUM_ELEM;
  localparam int IDX_W    = $clog2(NUM_ELEM + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  logic [IDX_W-1:0]     elem_cnt_reg;
  logic [FLAT_W-1:0]    asm_reg;
  logic [FLAT_W-1:0]    asm_next;
  logic [FLAT_W-1:0]    hold_reg;
  logic                 asm_full_reg;
  logic                 hold_full_reg;
  logic                 err_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  logic accept;
  logic at_last;
  logic early_last;
  logic complete;
  logic issue;
  logic load_hold;

  assign s_ready   = !asm_full_reg;
  assign mat_vld   = hold_full_reg & ready;
  assign mat_in    = hold_reg;
  assign err       = err_reg;
  assign mat_count = count_reg;

  assign accept     = s_valid & s_ready;
  assign at_last    = (elem_cnt_reg == LAST_IDX);
  assign early_last = accept & s_last & !at_last;
  assign complete   = accept & at_last;
  assign issue      = mat_vld;
  // A finished matrix goes straight to hold when hold is free or leaving on this edge.
  assign load_hold  = complete & (!hold_full_reg | issue);

  // Assembly image including the element accepted this cycle (element k at slot k).
  generate
    for (genvar gi = 0; gi < NUM_ELEM; gi++) begin : g_slot
      assign asm_next[gi*MAT_DWIDTH +: MAT_DWIDTH] =
        (elem_cnt_reg == IDX_W'(gi)) ? s_data : asm_reg[gi*MAT_DWIDTH +: MAT_DWIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      elem_cnt_reg  <= '0;
      asm_reg       <= '0;
      hold_reg      <= '0;
      asm_full_reg  <= 1'b0;
      hold_full_reg <= 1'b0;
      err_reg       <= 1'b0;
      count_reg     <= '0;
    end else begin
      if (accept) begin
        asm_reg      <= asm_next;
        elem_cnt_reg <= (early_last || at_last) ? '0 : elem_cnt_reg + 1'b1;
      end

      if (early_last || (complete && !s_last))
        err_reg <= 1'b1;

      if (issue)
        count_reg <= count_reg + 1'b1;

      if (load_hold) begin
        hold_reg      <= asm_next;
        hold_full_reg <= 1'b1;
      end else if (issue && asm_full_reg) begin
        hold_reg     <= asm_reg;
        asm_full_reg <= 1'b0;
      end else if (issue) begin
        hold_full_reg <= 1'b0;
      end

      // Hold is busy: park the finished matrix in assembly and stall the stream.
      if (complete && !load_hold)
        asm_full_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_invmat_loader.sv
// Directed bench for invmat_loader: streams matrices, captures issued matrices at
// the negative edge and compares them with hand-built expected matrices.
module tb_invmat_loader;

  localparam int N  = 5;
  localparam int W  = 46;
  localparam int CW = 16;
  localparam int NE = N * N;
  localparam int FW = W * NE;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          ready = 1'b0;
  logic          mat_vld;
  logic [FW-1:0] mat_in;
  logic          err;
  logic [CW-1:0] mat_count;

  int tests_run = 0;
  int tests_failed = 0;

  logic [FW-1:0] issued_q[$];
  int vld_cycles = 0;
  int acc_cnt = 0;
  int sready_low = 0;

  invmat_loader #(.MAT_SIZE(N), .MAT_DWIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .ready(ready), .mat_vld(mat_vld), .mat_in(mat_in),
    .err(err), .mat_count(mat_count)
  );

  always #5 clk = ~clk;

  // Inputs change 1ns after posedge, so at negedge both state and inputs are those
  // that the next posedge will act on.
  always @(negedge clk) begin
    if (!reset) begin
      if (mat_vld) begin
        issued_q.push_back(mat_in);
        vld_cycles++;
      end
      if (s_valid && s_ready) acc_cnt++;
      if (!s_ready) sready_low++;
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [W-1:0] elem_val(input int base, input int k, input bit neg);
    if (neg && k == 13) return 46'h3FFF_FFFF_FFFD;
    return W'(base + k + 1);
  endfunction

  function automatic logic [FW-1:0] make_mat(input int base, input bit neg);
    logic [FW-1:0] m;
    for (int k = 0; k < NE; k++) m[k*W +: W] = elem_val(base, k, neg);
    return m;
  endfunction

  task automatic push(input logic [W-1:0] d, input logic l);
    s_data = d; s_valid = 1'b1; s_last = l;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk); #1;
        s_valid = 1'b0; s_last = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    check("push_timeout", 0, 1);
  endtask

  // Send elements 0..n-1 of a matrix; s_last on element n-1 only if with_last.
  task automatic send_mat(input int base, input int n, input bit with_last, input bit neg);
    for (int k = 0; k < n; k++)
      push(elem_val(base, k, neg), (k == n - 1) && with_last);
  endtask

  task automatic check_mat(input string tag, input logic [FW-1:0] exp);
    logic [FW-1:0] got;
    int diffs;
    if (issued_q.size() == 0) begin
      check({tag, "_present"}, 0, 1);
      return;
    end
    got = issued_q.pop_front();
    diffs = 0;
    for (int k = 0; k < NE; k++) if (got[k*W +: W] !== exp[k*W +: W]) diffs++;
    check({tag, "_e0"}, 64'(got[0 +: W]), 64'(exp[0 +: W]));
    check({tag, "_e24"}, 64'(got[24*W +: W]), 64'(exp[24*W +: W]));
    check({tag, "_diffs"}, diffs, 0);
  endtask

  task automatic do_reset();
    s_valid = 1'b0; s_last = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issued_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base_vld;
  logic [FW-1:0] neg_mat;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_mat_vld", mat_vld, 0);
    check("rst_mat_in_zero", |mat_in, 0);
    check("rst_err", err, 0);
    check("rst_mat_count", mat_count, 0);
    @(posedge clk); #1 reset = 1'b0;

    // Single matrix 1..25 with ready high
    ready = 1'b1;
    base_vld = vld_cycles;
    send_mat(0, NE, 1, 0);
    @(negedge clk);
    check("single_vld_next_cycle", mat_vld, 1);
    idle(4);
    check("single_vld_cycles", vld_cycles - base_vld, 1);
    check("single_count", mat_count, 1);
    check("single_err", err, 0);
    check_mat("single", make_mat(0, 0));

    // Negative element at (2,3)
    neg_mat = make_mat(200, 1);
    send_mat(200, NE, 1, 1);
    idle(3);
    if (issued_q.size() > 0) check("neg_field13", 64'(issued_q[0][13*W +: W]), 64'h3FFF_FFFF_FFFD);
    else check("neg_present", 0, 1);
    check_mat("neg", neg_mat);
    check("neg_count", mat_count, 2);

    // Backpressure: A, B, C with ready low
    ready = 1'b0;
    base_vld = acc_cnt;
    fork
      begin
        send_mat(300, NE, 1, 0);
        send_mat(400, NE, 1, 0);
        send_mat(500, NE, 1, 0);
      end
      begin
        for (int t = 0; t < 200 && s_ready; t++) @(negedge clk);
        check("bp_accepted_at_stall", acc_cnt - base_vld, 2 * NE);
        repeat (10) @(negedge clk);
        check("bp_still_stalled", acc_cnt - base_vld, 2 * NE);
        check("bp_s_ready_low", s_ready, 0);
        check("bp_none_issued", issued_q.size(), 0);
        @(posedge clk); #1 ready = 1'b1;
      end
    join
    idle(4);
    check_mat("bp_A", make_mat(300, 0));
    check_mat("bp_B", make_mat(400, 0));
    check_mat("bp_C", make_mat(500, 0));
    check("bp_count", mat_count, 5);

    // B completes on the edge that A transfers
    ready = 1'b0;
    sready_low = 0;
    send_mat(600, NE, 1, 0);
    send_mat(700, NE - 1, 0, 0);
    ready = 1'b1;
    push(elem_val(700, NE - 1, 0), 1'b1);
    @(negedge clk);
    check("simul_vld_after", mat_vld, 1);
    idle(3);
    check("simul_s_ready_never_low", sready_low, 0);
    check_mat("simul_A", make_mat(600, 0));
    check_mat("simul_B", make_mat(700, 0));
    check("simul_count", mat_count, 7);

    // Early s_last on element 10
    send_mat(800, 10, 1, 0);
    idle(4);
    check("early_err", err, 1);
    check("early_none_issued", issued_q.size(), 0);
    check("early_count", mat_count, 7);
    send_mat(900, NE, 1, 0);
    idle(3);
    check_mat("after_early", make_mat(900, 0));
    check("after_early_count", mat_count, 8);
    check("after_early_err_sticky", err, 1);

    // Missing s_last on element 25
    do_reset();
    check("reset_err_clear", err, 0);
    send_mat(1000, NE, 0, 0);
    idle(3);
    check("nolast_err", err, 1);
    check_mat("nolast", make_mat(1000, 0));
    check("nolast_count", mat_count, 1);

    // Reset mid-matrix
    do_reset();
    send_mat(1100, 12, 0, 0);
    reset = 1'b1;
    #1;
    check("midrst_count_async", mat_count, 0);
    check("midrst_s_ready", s_ready, 1);
    do_reset();
    send_mat(1200, NE, 1, 0);
    idle(3);
    check("midrst_issued_one", issued_q.size(), 1);
    check_mat("midrst", make_mat(1200, 0));
    check("midrst_count", mat_count, 1);
    check("midrst_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
